// File: rtl/mux8_arb_16b_if.sv
// Shared-channel bundle between the eight producers, the arbiter and the single consumer port.
// The arbiter side uses the slave modport; producers/consumer (or a bench) use master.
interface mux8_arb_16b_if;
    logic [7:0]  req;
    logic [7:0]  last;
    logic [15:0] InA;
    logic [15:0] InB;
    logic [15:0] InC;
    logic [15:0] InD;
    logic [15:0] InE;
    logic [15:0] InF;
    logic [15:0] InG;
    logic [15:0] InH;
    logic        out_ready;
    logic        out_valid;
    logic        out_last;
    logic [15:0] Out;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        err;

    modport master (
        output req, last, InA, InB, InC, InD, InE, InF, InG, InH, out_ready,
        input  out_valid, out_last, Out, gnt, sel, err
    );

    modport slave (
        input  req, last, InA, InB, InC, InD, InE, InF, InG, InH, out_ready,
        output out_valid, out_last, Out, gnt, sel, err
    );
endinterface

// File: rtl/mux8_arb_16b.sv
// Round-robin burst arbiter sharing one 16-bit channel among eight requesters,
// with an 8:1 data mux, valid/ready beat handshake and stall timeout.

module mux8_16b (
    input  logic [2:0]  i_sel,
    input  logic [15:0] i_d0,
    input  logic [15:0] i_d1,
    input  logic [15:0] i_d2,
    input  logic [15:0] i_d3,
    input  logic [15:0] i_d4,
    input  logic [15:0] i_d5,
    input  logic [15:0] i_d6,
    input  logic [15:0] i_d7,
    output logic [15:0] o_y
);
    always_comb begin
        o_y = i_d0;
        case (i_sel)
            3'd0: o_y = i_d0;
            3'd1: o_y = i_d1;
            3'd2: o_y = i_d2;
            3'd3: o_y = i_d3;
            3'd4: o_y = i_d4;
            3'd5: o_y = i_d5;
            3'd6: o_y = i_d6;
            3'd7: o_y = i_d7;
            default: o_y = i_d0;
        endcase
    end
endmodule

module mux8_arb_16b #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    mux8_arb_16b_if.slave bus,
    output logic         o_dbg_busy,
    output logic [2:0]   o_dbg_ptr,
    output logic [7:0]   o_dbg_tcnt
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [2:0]  r_ptr;
    logic [2:0]  r_sel;
    logic [7:0]  r_gnt;
    logic [7:0]  r_tcnt;
    logic        r_err;

    logic        w_busy;
    logic        w_req_sel;
    logic        w_valid;
    logic        w_last;
    logic        w_xfer;
    logic        w_found;
    logic [2:0]  w_pick;
    logic [2:0]  w_idx;
    logic [15:0] w_mux;

    mux8_16b u_mux (
        .i_sel (r_sel),
        .i_d0  (bus.InA),
        .i_d1  (bus.InB),
        .i_d2  (bus.InC),
        .i_d3  (bus.InD),
        .i_d4  (bus.InE),
        .i_d5  (bus.InF),
        .i_d6  (bus.InG),
        .i_d7  (bus.InH),
        .o_y   (w_mux)
    );

    // Handshake: a beat moves on any rising edge where out_valid and out_ready are
    // both high; out_valid is the owner's req bit, so an owner may stall but never
    // withdraw a beat that is mid-handshake without also starting the timeout.
    assign w_busy    = (r_state == BUSY);
    assign w_req_sel = bus.req[r_sel];
    assign w_valid   = w_busy & w_req_sel;
    assign w_last    = w_valid & bus.last[r_sel];
    assign w_xfer    = w_valid & bus.out_ready;

    assign bus.out_valid = w_valid;
    assign bus.out_last  = w_last;
    assign bus.Out       = w_busy ? w_mux : 16'h0000;
    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.err       = r_err;

    assign o_dbg_busy = w_busy;
    assign o_dbg_ptr  = r_ptr;
    assign o_dbg_tcnt = r_tcnt;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_idx = r_ptr + 3'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_sel   <= 3'd0;
            r_gnt   <= 8'h00;
            r_tcnt  <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_pick;
                        r_gnt   <= 8'h01 << w_pick;
                        r_tcnt  <= 8'h00;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_xfer && w_last) begin
                        r_state <= IDLE;
                        r_gnt   <= 8'h00;
                        r_ptr   <= r_sel + 3'd1;
                        r_tcnt  <= 8'h00;
                    end else if (!w_req_sel) begin
                        if (r_tcnt == TMAX) begin
                            r_state <= IDLE;
                            r_gnt   <= 8'h00;
                            r_ptr   <= r_sel + 3'd1;
                            r_tcnt  <= 8'h00;
                            r_err   <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + 8'd1;
                        end
                    end else begin
                        // Backpressure with req held is not a stall.
                        r_tcnt <= 8'h00;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux8_arb_16b.sv
// Directed bench for mux8_arb_16b: priority, wrap, backpressure, timeout,
// asynchronous reset mid-burst and non-owner request noise.
module tb_mux8_arb_16b;
    logic       clk;
    logic       rst;
    logic       dbg_busy;
    logic [2:0] dbg_ptr;
    logic [7:0] dbg_tcnt;
    int         n_cmp;
    int         n_bad;
    int         b;
    int         nx;

    mux8_arb_16b_if bus();

    mux8_arb_16b #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_dbg_busy (dbg_busy),
        .o_dbg_ptr  (dbg_ptr),
        .o_dbg_tcnt (dbg_tcnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req = 8'h00;
        bus.last = 8'h00;
        bus.out_ready = 1'b0;
        bus.InA = 16'h1111; bus.InB = 16'h2222; bus.InC = 16'h3333; bus.InD = 16'h4444;
        bus.InE = 16'h5555; bus.InF = 16'h6666; bus.InG = 16'h7777; bus.InH = 16'h8888;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_out", 32'(bus.Out), 0);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_ptr", 32'(dbg_ptr), 0);
        rst = 1'b0;

        // priority and single-beat bursts
        bus.req = 8'b0000_0101;
        bus.last = 8'hFF;
        bus.out_ready = 1'b1;
        #1;
        chk("idle_valid", 32'(bus.out_valid), 0);
        step();
        chk("p_gnt0", 32'(bus.gnt), 32'h01);
        chk("p_out0", 32'(bus.Out), 32'h1111);
        chk("p_last0", 32'(bus.out_last), 1);
        step();
        chk("p_bubble_gnt", 32'(bus.gnt), 0);
        chk("p_bubble_out", 32'(bus.Out), 0);
        chk("p_ptr1", 32'(dbg_ptr), 1);
        step();
        chk("p_gnt2", 32'(bus.gnt), 32'h04);
        chk("p_out2", 32'(bus.Out), 32'h3333);
        step();
        chk("p_end_gnt", 32'(bus.gnt), 0);
        chk("p_ptr3", 32'(dbg_ptr), 3);
        bus.req = 8'h00;

        // round-robin wrap
        bus.req = 8'b0100_0000;
        step();
        chk("w_gnt6", 32'(bus.gnt), 32'h40);
        chk("w_out6", 32'(bus.Out), 32'h7777);
        step();
        chk("w_ptr7", 32'(dbg_ptr), 7);
        bus.req = 8'b1000_0001;
        step();
        chk("w_gnt7", 32'(bus.gnt), 32'h80);
        chk("w_sel7", 32'(bus.sel), 7);
        chk("w_out7", 32'(bus.Out), 32'h8888);
        step();
        chk("w_ptr0", 32'(dbg_ptr), 0);
        step();
        chk("w_gnt0", 32'(bus.gnt), 32'h01);
        step();
        chk("w_ptr1", 32'(dbg_ptr), 1);
        bus.req = 8'h00;

        // multi-beat with backpressure, requester 3
        bus.req = 8'h08;
        bus.last = 8'h00;
        bus.out_ready = 1'b0;
        bus.InD = 16'hD000;
        step();
        chk("bp_gnt_first", 32'(bus.gnt), 32'h08);
        chk("bp_sel", 32'(bus.sel), 3);
        chk("bp_valid", 32'(bus.out_valid), 1);
        b = 0;
        nx = 0;
        for (int c = 0; c < 20 && b < 4; c++) begin
            bus.out_ready = (c % 2 == 0);
            bus.last = (b == 3) ? 8'h08 : 8'h00;
            bus.InD = 16'hD000 + 16'(b);
            #1;
            chk("bp_gnt", 32'(bus.gnt), 32'h08);
            chk("bp_tcnt", 32'(dbg_tcnt), 0);
            chk("bp_last", 32'(bus.out_last), 32'(b == 3));
            chk("bp_out", 32'(bus.Out), 32'h0000D000 + 32'(b));
            if (bus.out_valid && bus.out_ready) nx++;
            if (c % 2 == 0) b++;
            step();
        end
        chk("bp_xfers", 32'(nx), 4);
        chk("bp_end_gnt", 32'(bus.gnt), 0);
        chk("bp_ptr4", 32'(dbg_ptr), 4);
        bus.req = 8'h00;
        bus.out_ready = 1'b1;

        // timeout: requester 2 stalls while requester 5 waits
        bus.req = 8'b0000_0100;
        step();
        chk("t_gnt2", 32'(bus.gnt), 32'h04);
        bus.req = 8'b0010_0000;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) begin
                chk("t_hold_gnt", 32'(bus.gnt), 32'h04);
                chk("t_no_err", 32'(bus.err), 0);
            end else begin
                chk("t_drop_gnt", 32'(bus.gnt), 0);
                chk("t_err", 32'(bus.err), 1);
                chk("t_ptr3", 32'(dbg_ptr), 3);
            end
            if (k == 8) chk("t_tcnt8", 32'(dbg_tcnt), 8);
        end
        step();
        chk("t_err_clr", 32'(bus.err), 0);
        chk("t_gnt5", 32'(bus.gnt), 32'h20);
        chk("t_sel5", 32'(bus.sel), 5);
        bus.last = 8'hFF;
        step();
        chk("t_ptr6", 32'(dbg_ptr), 6);
        bus.req = 8'h00;

        // asynchronous reset during beat 2 of 4
        bus.req = 8'h01;
        bus.last = 8'h00;
        step();
        chk("r_gnt0", 32'(bus.gnt), 32'h01);
        step();
        chk("r_beat2_valid", 32'(bus.out_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("r_gnt", 32'(bus.gnt), 0);
        chk("r_valid", 32'(bus.out_valid), 0);
        chk("r_out", 32'(bus.Out), 0);
        step();
        chk("r_hold_valid", 32'(bus.out_valid), 0);
        chk("r_ptr0", 32'(dbg_ptr), 0);
        rst = 1'b0;
        step();
        chk("r_regnt", 32'(bus.gnt), 32'h01);
        bus.last = 8'h01;
        step();
        chk("r_ptr1", 32'(dbg_ptr), 1);
        bus.req = 8'h00;
        bus.last = 8'h00;

        // non-owner noise during requester 4's burst
        bus.req = 8'h10;
        step();
        chk("n_gnt_first", 32'(bus.gnt), 32'h10);
        for (int c = 0; c < 6; c++) begin
            bus.req = ((c % 2 != 0) ? 8'hEF : 8'h00) | 8'h10;
            bus.last = ((c % 2 != 0) ? 8'hAF : 8'h00) | ((c == 5) ? 8'h10 : 8'h00);
            #1;
            chk("n_gnt", 32'(bus.gnt), 32'h10);
            chk("n_sel", 32'(bus.sel), 4);
            step();
        end
        chk("n_end_gnt", 32'(bus.gnt), 0);
        chk("n_ptr5", 32'(dbg_ptr), 5);
        bus.req = 8'h00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
